// File: rtl/paddle_emulator.sv
// paddle_emulator: drives the hpaddle/vpaddle lines of the analog-paddle timing
// interface from 8-bit digital positions. Each line is held low on scanlines
// 0..thr and high otherwise, so a receiver latching vpos on each hsync rise
// while the line is low ends the frame holding thr.
//
// Optional feature: define PADDLE_EMU_JITTER_EN to add 0/+1 line of pot noise
// from an 8-bit LFSR that steps once per frame.
//
// Position handshake (valid/ready): a pair is transferred on any clock edge where
// i_pos_valid and o_pos_ready are both high; a sender seeing o_pos_ready low must
// keep i_pos_valid and the data stable until that transfer edge. The accepted pair
// waits in a one-deep pending slot and becomes the active threshold at the next
// vsync rise; the slot reopens the cycle after that load.
module paddle_emulator (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_hsync,
    input  logic       i_vsync,
    input  logic [8:0] i_vpos,
    input  logic [7:0] i_pos_x,
    input  logic [7:0] i_pos_y,
    input  logic       i_pos_valid,
    output logic       o_pos_ready,
    output logic       o_hpaddle,
    output logic       o_vpaddle,
    output logic [1:0] o_dbg_state_x,
    output logic [1:0] o_dbg_state_y
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CHARGING = 2'd1,
        ST_TRIPPED  = 2'd2
    } state_t;

    logic       r_hsync_d;
    logic       r_vsync_d;
    logic       w_hs_fall;
    logic       w_vs_rise;

    logic       r_pend_full;
    logic [7:0] r_pend_x;
    logic [7:0] r_pend_y;
    logic [7:0] r_thr_x;
    logic [7:0] r_thr_y;
    logic       w_accept;

    logic [7:0] w_eff_x;
    logic [7:0] w_eff_y;

    state_t     r_state_x;
    state_t     r_state_y;
    state_t     w_next_x;
    state_t     w_next_y;
    logic       r_hpaddle;
    logic       r_vpaddle;

    // Delay the sync inputs by one clock for edge detection
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hsync_d <= 1'b0;
            r_vsync_d <= 1'b0;
        end else begin
            r_hsync_d <= i_hsync;
            r_vsync_d <= i_vsync;
        end
    end

    assign w_hs_fall   = r_hsync_d & ~i_hsync;
    assign w_vs_rise   = ~r_vsync_d & i_vsync;
    assign o_pos_ready = ~r_pend_full;
    assign w_accept    = i_pos_valid & o_pos_ready;

    // Pending slot and frame-boundary threshold load; an accept on the loading
    // vsync edge cannot happen because the slot is full then, and an accept on a
    // vsync edge with an empty slot simply waits for the next frame
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pend_full <= 1'b0;
            r_pend_x    <= 8'd0;
            r_pend_y    <= 8'd0;
            r_thr_x     <= 8'd128;
            r_thr_y     <= 8'd128;
        end else begin
            if (w_vs_rise && r_pend_full) begin
                r_thr_x <= r_pend_x;
                r_thr_y <= r_pend_y;
            end
            if (w_accept) begin
                r_pend_x    <= i_pos_x;
                r_pend_y    <= i_pos_y;
                r_pend_full <= 1'b1;
            end else if (w_vs_rise && r_pend_full) begin
                r_pend_full <= 1'b0;
            end
        end
    end

`ifdef PADDLE_EMU_JITTER_EN
    logic [7:0] r_lfsr;
    logic [8:0] w_sum_x;
    logic [8:0] w_sum_y;

    // Fibonacci LFSR, taps 8,6,5,4, one step per frame
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lfsr <= 8'h01;
        end else if (w_vs_rise) begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_sum_x = {1'b0, r_thr_x} + {8'd0, r_lfsr[0]};
    assign w_sum_y = {1'b0, r_thr_y} + {8'd0, r_lfsr[1]};
    assign w_eff_x = w_sum_x[8] ? 8'hFF : w_sum_x[7:0];
    assign w_eff_y = w_sum_y[8] ? 8'hFF : w_sum_y[7:0];
`else
    assign w_eff_x = r_thr_x;
    assign w_eff_y = r_thr_y;
`endif

    // One channel's transition on an hsync fall; IDLE behaves like TRIPPED so the
    // line stays high until the first line 0 after reset
    function automatic state_t next_state(input state_t st, input logic [8:0] vpos,
                                          input logic [7:0] thr);
        state_t nx;
        nx = st;
        case (st)
            ST_CHARGING: begin
                if (vpos > {1'b0, thr}) nx = ST_TRIPPED;
            end
            default: begin
                if (vpos == 9'd0) nx = (vpos > {1'b0, thr}) ? ST_TRIPPED : ST_CHARGING;
            end
        endcase
        return nx;
    endfunction

    // Next-state logic for both channels, only moving on an hsync fall
    always_comb begin
        w_next_x = r_state_x;
        w_next_y = r_state_y;
        if (w_hs_fall) begin
            w_next_x = next_state(r_state_x, i_vpos, w_eff_x);
            w_next_y = next_state(r_state_y, i_vpos, w_eff_y);
        end
    end

    // State and registered line outputs; reset forces both lines high at once
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state_x <= ST_IDLE;
            r_state_y <= ST_IDLE;
            r_hpaddle <= 1'b1;
            r_vpaddle <= 1'b1;
        end else begin
            r_state_x <= w_next_x;
            r_state_y <= w_next_y;
            r_hpaddle <= (w_next_x != ST_CHARGING);
            r_vpaddle <= (w_next_y != ST_CHARGING);
        end
    end

    assign o_hpaddle     = r_hpaddle;
    assign o_vpaddle     = r_vpaddle;
    assign o_dbg_state_x = r_state_x;
    assign o_dbg_state_y = r_state_y;

endmodule

// File: tb/tb_paddle_emulator.sv
// tb_paddle_emulator: drives a small video timing (8 clocks per line, 262 lines
// per frame, hsync low on clocks 2..4, vsync high on lines 258..260), feeds
// position pairs through the handshake and compares the paddle lines, ready
// and the frame-end receiver reading against a frame-level reference model.
module tb_paddle_emulator;

  localparam int LINE_CLKS = 8;
  localparam int FRAME_LINES = 262;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_hsync;
  logic       i_vsync;
  logic [8:0] i_vpos;
  logic [7:0] i_pos_x;
  logic [7:0] i_pos_y;
  logic       i_pos_valid;
  logic       o_pos_ready;
  logic       o_hpaddle;
  logic       o_vpaddle;
  logic [1:0] o_dbg_state_x;
  logic [1:0] o_dbg_state_y;

  paddle_emulator dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_hsync      (i_hsync),
    .i_vsync      (i_vsync),
    .i_vpos       (i_vpos),
    .i_pos_x      (i_pos_x),
    .i_pos_y      (i_pos_y),
    .i_pos_valid  (i_pos_valid),
    .o_pos_ready  (o_pos_ready),
    .o_hpaddle    (o_hpaddle),
    .o_vpaddle    (o_vpaddle),
    .o_dbg_state_x(o_dbg_state_x),
    .o_dbg_state_y(o_dbg_state_y)
  );

  // clock
  always #5 i_clk = ~i_clk;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  // reference model state
  logic [7:0]  m_thr_x, m_thr_y, m_pend_x, m_pend_y, m_lfsr;
  bit          m_pend, m_seen0;
  logic        m_exp_h, m_exp_v;
  logic [15:0] req_q[$];
  bit          sch_req_en = 0;
  int          sch_line, sch_cyc;
  logic [15:0] sch_val;
  bit          sch_rst_en = 0;
  int          sch_rst_line, sch_rst_cyc;
  logic [8:0]  rx_x, rx_y;
  logic [7:0]  exp_rd_x, exp_rd_y;
  bit          frame_ok = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] eff(input logic [7:0] thr, input logic b);
    int s;
    s = int'(thr) + int'(b);
    if (s > 255) s = 255;
    return 8'(s);
  endfunction

  function automatic logic jit_x();
`ifdef PADDLE_EMU_JITTER_EN
    return m_lfsr[0];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic jit_y();
`ifdef PADDLE_EMU_JITTER_EN
    return m_lfsr[1];
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_thr_x = 8'd128; m_thr_y = 8'd128;
    m_pend = 0; m_lfsr = 8'h01; m_seen0 = 0;
    m_exp_h = 1'b1; m_exp_v = 1'b1;
    frame_ok = 0;
  endtask

  // one pixel clock of stimulus, followed by model update and checks
  task automatic do_cycle(input int line, input int cyc);
    bit vs_rise, rst, acc;
    logic [15:0] head;
    if (sch_req_en && line == sch_line && cyc == sch_cyc) begin
      req_q.push_back(sch_val);
      sch_req_en = 0;
    end
    rst = sch_rst_en && line == sch_rst_line && cyc == sch_rst_cyc;
    if (rst) begin
      sch_rst_en = 0;
      req_q.delete();
    end
    i_reset = rst;
    i_vpos  = line[8:0];
    i_hsync = !(cyc >= 2 && cyc <= 4);
    i_vsync = (line >= 258 && line <= 260);
    if (req_q.size() > 0) begin
      head = req_q[0];
      i_pos_valid = 1'b1;
      i_pos_x = head[15:8];
      i_pos_y = head[7:0];
    end else begin
      i_pos_valid = 1'b0;
      i_pos_x = 8'($urandom_range(0, 255));
      i_pos_y = 8'($urandom_range(0, 255));
    end
    vs_rise = (line == 258 && cyc == 0);
    acc = i_pos_valid && !m_pend && !rst;

    @(posedge i_clk);
    #1;

    // receiver: latch vpos on the hsync rise while the line is low
    if (cyc == 5) begin
      if (o_hpaddle === 1'b0) rx_x = line[8:0];
      if (o_vpaddle === 1'b0) rx_y = line[8:0];
    end

    if (rst) begin
      model_reset();
    end else begin
      if (vs_rise) begin
        if (m_pend) begin
          m_thr_x = m_pend_x; m_thr_y = m_pend_y; m_pend = 0;
        end
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      end
      if (acc) begin
        m_pend = 1; m_pend_x = i_pos_x; m_pend_y = i_pos_y;
        void'(req_q.pop_front());
      end
      if (cyc == 2) begin
        if (line == 0) begin
          m_seen0 = 1;
          frame_ok = 1;
          rx_x = 9'h1FF; rx_y = 9'h1FF;
          exp_rd_x = eff(m_thr_x, jit_x());
          exp_rd_y = eff(m_thr_y, jit_y());
        end
        if (m_seen0) begin
          m_exp_h = (line <= int'(eff(m_thr_x, jit_x()))) ? 1'b0 : 1'b1;
          m_exp_v = (line <= int'(eff(m_thr_y, jit_y()))) ? 1'b0 : 1'b1;
        end else begin
          m_exp_h = 1'b1; m_exp_v = 1'b1;
        end
      end
    end

    chk("pos_ready", o_pos_ready, !m_pend);
    chk("hpaddle", o_hpaddle, m_exp_h);
    chk("vpaddle", o_vpaddle, m_exp_v);
    if (line == FRAME_LINES - 1 && cyc == LINE_CLKS - 1 && frame_ok) begin
      chk("read_x", rx_x, exp_rd_x);
      chk("read_y", rx_y, exp_rd_y);
    end
  endtask

  task automatic run_frame();
    for (int l = 0; l < FRAME_LINES; l++)
      for (int c = 0; c < LINE_CLKS; c++)
        do_cycle(l, c);
  endtask

  task automatic sched_req(input int line, input int cyc, input logic [7:0] x, input logic [7:0] y);
    sch_req_en = 1; sch_line = line; sch_cyc = cyc; sch_val = {x, y};
  endtask

  initial begin
    // reset
    i_reset = 1'b1; i_hsync = 1'b1; i_vsync = 1'b0; i_vpos = 9'd0;
    i_pos_valid = 1'b0; i_pos_x = 8'd0; i_pos_y = 8'd0;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_ready", o_pos_ready, 1);
    chk("reset_hpaddle", o_hpaddle, 1);
    chk("reset_vpaddle", o_vpaddle, 1);

    // two frames with default thresholds
    run_frame();
    run_frame();
`ifndef PADDLE_EMU_JITTER_EN
    chk("default_read_x", rx_x, 128);
    chk("default_read_y", rx_y, 128);
`endif

    // extreme positions
    sched_req(100, 3, 8'd0, 8'd255);
    run_frame();
    run_frame();
`ifndef PADDLE_EMU_JITTER_EN
    chk("extreme_read_x", rx_x, 0);
    chk("extreme_read_y", rx_y, 255);
`endif

    // back-to-back requests in one frame; the second waits for the slot
    req_q.push_back({8'd10, 8'd20});
    req_q.push_back({8'd30, 8'd40});
    run_frame();
    run_frame();
`ifndef PADDLE_EMU_JITTER_EN
    chk("b2b_first_x", rx_x, 10);
    chk("b2b_first_y", rx_y, 20);
`endif

    // accept on the vsync-rise cycle lands one frame late
    sched_req(258, 0, 8'd70, 8'd80);
    run_frame();
`ifndef PADDLE_EMU_JITTER_EN
    chk("b2b_second_x", rx_x, 30);
`endif
    run_frame();
`ifndef PADDLE_EMU_JITTER_EN
    chk("vsedge_unchanged_x", rx_x, 30);
    chk("vsedge_unchanged_y", rx_y, 40);
`endif
    sched_req(20, 5, 8'd100, 8'd100);
    run_frame();
`ifndef PADDLE_EMU_JITTER_EN
    chk("vsedge_loaded_x", rx_x, 70);
    chk("vsedge_loaded_y", rx_y, 80);
`endif

    // reset mid-frame at line 50 with thr=100
    sch_rst_en = 1; sch_rst_line = 50; sch_rst_cyc = 6;
    run_frame();
    run_frame();
`ifndef PADDLE_EMU_JITTER_EN
    chk("post_reset_read_x", rx_x, 128);
`endif

    // randomized positions at random points in the frame
    for (int f = 0; f < 3; f++) begin
      sched_req($urandom_range(0, FRAME_LINES - 1), $urandom_range(0, LINE_CLKS - 1),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      run_frame();
    end
    run_frame();

`ifdef PADDLE_EMU_JITTER_EN
    begin
      bit seen100, seen101;
      seen100 = 0; seen101 = 0;
      req_q.push_back({8'd255, 8'd255});
      run_frame();
      run_frame();
      chk("jit_sat_x", rx_x, 255);
      chk("jit_sat_y", rx_y, 255);
      req_q.push_back({8'd100, 8'd100});
      run_frame();
      for (int f = 0; f < 16; f++) begin
        run_frame();
        chk("jit_range_x", (rx_x == 9'd100 || rx_x == 9'd101), 1);
        if (rx_x == 9'd100) seen100 = 1;
        if (rx_x == 9'd101) seen101 = 1;
      end
      chk("jit_seen_both", {seen100, seen101}, 2'b11);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/paddle_emulator.md
# paddle_emulator

Generates the `hpaddle`/`vpaddle` lines that a paddle-reading game samples. It drives the transmitter side of the analog-paddle timing interface from digital 8-bit positions. Each frame, each line stays low from scanline 0 through the programmed position, then goes high (tripped) until the next frame. A receiver that latches `vpos[7:0]` on every `hsync` rise while the line is low therefore ends the frame holding exactly the programmed value. The block sits beside `hvsync_generator` and is fed by a test host or input decoder.

## Interface
- (no parameters)
- clk  in  1  pixel clock; all logic on posedge
- reset  in  1  synchronous, active-high
- hsync  in  1  from `hvsync_generator`, sampled in the `clk` domain
- vsync  in  1  from `hvsync_generator`, sampled in the `clk` domain
- vpos  in  9  current scanline from `hvsync_generator`
- pos_x  in  8  requested horizontal paddle position
- pos_y  in  8  requested vertical paddle position
- pos_valid  in  1  `pos_x`/`pos_y` valid this cycle
- pos_ready  out  1  block can accept a position pair
- hpaddle  out  1  emulated horizontal paddle line
- vpaddle  out  1  emulated vertical paddle line

## Operation
- Edge detect: `hsync_d` and `vsync_d` registers.
  - `hs_fall = hsync_d & ~hsync`
  - `vs_rise = ~vsync_d & vsync`
- Handshake:
  - Accept occurs when `pos_valid && pos_ready`. Both values are stored in `pend_x`/`pend_y`, and `pend_full` is set.
  - `pos_ready = ~pend_full`.
  - `pos_valid` while not ready is ignored; the sender holds its request.
- Frame load: on `vs_rise` with `pend_full`, `thr_x <= pend_x`, `thr_y <= pend_y`, and `pend_full` is cleared.
  - An accept in the same cycle as `vs_rise` while `pend_full=0` lands in pending and is loaded at the next `vs_rise`. There is no bypass.
- Per-channel FSM, identical for x and y, evaluated only on `hs_fall` using the current `vpos`:
  - CHARGING (output 0): if `vpos > {1'b0,thr}`, go to TRIPPED.
  - TRIPPED (output 1): if `vpos == 0`, go to CHARGING and re-evaluate against thr in the same cycle. This means thr=0 still gives a low line 0.
  - IDLE (output 1, after reset): on the first `hs_fall` with `vpos == 0`, behave as TRIPPED→CHARGING.
  - Comparison is 9-bit unsigned. Because thr ≤ 255, every line from 256 up, including vsync/blanking, is TRIPPED. The line never goes low during vblank.
- Output is low on lines 0..thr inclusive and high otherwise. The receiver's last latch in the frame is thr.
- Reset mid-frame: both outputs go high immediately and stay high until the next line 0, so there is no partial low window.

## Timing
- Outputs are registered. They change on the `clk` edge after the first cycle in which `hsync` is sampled low, i.e. 1 clk after `hs_fall` is detected. They are stable through the following `hsync` rise.
- Position-to-output latency is the next `vs_rise` plus the next line-0 `hs_fall`. Values never change mid-frame.
- `pos_ready` deasserts the cycle after accept and reasserts the cycle after the loading `vs_rise`.
- Reset values:
  - `hpaddle=1`, `vpaddle=1`, `pos_ready=1`
  - `thr_x=thr_y=8'd128`, `pend_full=0`
  - FSMs in IDLE; `hsync_d=vsync_d=0`

## Configuration
- `PADDLE_EMU_JITTER_EN` defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'h01) steps on every `vs_rise`.
  - The effective compare threshold per channel is `thr + lfsr[0]` (x) and `thr + lfsr[1]` (y), saturating at 255.
  - This models pot noise of 0/+1 line.
- Undefined: no LFSR; the threshold equals thr exactly.

## Test plan
- Reset, then run 2 frames with no handshake → the receiver model reads 128/128. `hpaddle` is low on vpos 0..128 and high on 129..261.
- Accept `pos_x=0`, `pos_y=255` → `pos_ready` drops. After the next `vs_rise`, ready rises. The following frame has `hpaddle` low only on line 0 and `vpaddle` low on lines 0..255; the receiver reads 0/255.
- Two back-to-back `pos_valid` pulses (10/20, then 30/40) within one frame → only 10/20 is accepted (ready=0 on the second). The second is accepted after `vs_rise` and appears one frame later.
- Accept in the same cycle as `vs_rise` → thresholds are unchanged for the next frame and updated the frame after.
- Assert reset at vpos=50 with thr=100 → outputs go high the next cycle and stay high through line 261. The normal pattern resumes at line 0.
- With `PADDLE_EMU_JITTER_EN`, pos_x=255 → the read value is always 255 (saturation). With pos_x=100, reads stay within {100,101} over 16 frames and both values occur.
